mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
- REQ-001: Parameter MULT_CYCLES, default 5, is the number of Busy cycles for MULT/MULTU.
- REQ-002: Parameter DIV_CYCLES, default 10, is the number of Busy cycles for DIV/DIVU.
- REQ-003: Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
- REQ-004: Port reset, input, 1 bit, is the asynchronous, active-high reset.
- REQ-005: Port A, input, 32 bits, is the forwarded rs operand from Execute.
- REQ-006: Port B, input, 32 bits, is the forwarded rt operand from Execute.
- REQ-007: Port MDOp, input, 3 bits, is the operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- REQ-008: Port Start, input, 1 bit, is asserted for one cycle with MDOp 1–4 to launch an operation.
- REQ-009: Port Busy, output, 1 bit, is high while an operation is in flight.
- REQ-010: Port HI, output, 32 bits, is the current HI register.
- REQ-011: Port LO, output, 32 bits, is the current LO register.

Function
- REQ-012: The block SHALL implement a two-state FSM: IDLE and RUN.
- REQ-013: In IDLE, Start=1 with MDOp 1–4 at edge k SHALL latch A and B, latch MDOp, load a cycle counter with N (MULT_CYCLES or DIV_CYCLES), and enter RUN.
- REQ-014: Busy SHALL be high from just after edge k until edge k+N, and low in IDLE.
- REQ-015: In RUN, the counter SHALL decrement each edge; at edge k+N, HI/LO SHALL take the result, Busy SHALL fall, and the FSM SHALL return to IDLE.
- REQ-016: HI/LO SHALL hold their old values throughout RUN; no intermediate value SHALL be visible.
- REQ-017: MULT SHALL produce the signed 64-bit product, MULTU the unsigned 64-bit product; HI gets bits 63:32 and LO gets bits 31:0.
- REQ-018: DIV SHALL set LO = signed quotient truncated toward zero and HI = remainder with the sign of the dividend; DIVU SHALL do the same unsigned.
- REQ-019: DIV with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
- REQ-020: DIV/DIVU with B=0 SHALL still take DIV_CYCLES with Busy high, then leave HI and LO unchanged.
- REQ-021: Start with MDOp 1–4 while in RUN SHALL be ignored (the Control stall on Start|Busy prevents it); the in-flight operation SHALL be unaffected.
- REQ-022: MDOp=MTHI (or MTLO), in IDLE with Start=0, SHALL write A into HI (or LO) at the next edge; in RUN it SHALL be ignored.
- REQ-023: Start with MDOp 0, 5, 6 or 7 SHALL NOT enter RUN.
- REQ-024: Results SHALL depend only on the operands latched at launch; changes on A/B during RUN SHALL have no effect.

Reset
- REQ-025: Asserting reset at any time, including mid-RUN, SHALL immediately force IDLE, Busy=0, HI=0, LO=0, and counter=0, with no clock required.
- REQ-026: An operation in flight at reset SHALL be discarded and SHALL never write HI/LO.
- REQ-027: After reset deasserts, the first Start SHALL behave exactly as in REQ-013.

Verification
- REQ-028: A=0xFFFFFFFE, B=3, MULT, Start at edge k -> Busy high for 5 cycles; at edge k+5, HI=0xFFFFFFFF and LO=0xFFFFFFFA, Busy=0.
- REQ-029: Same operands, MULTU -> at edge k+5, HI=0x00000002 and LO=0xFFFFFFFA.
- REQ-030: A=0xFFFFFFF9 (−7), B=2, DIV -> Busy high for 10 cycles; then LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU with A=7, B=0 -> Busy high for 10 cycles; then HI/LO unchanged.
- REQ-031: MULT launched, then at cycle 2 of RUN: a second Start with DIV, MTLO with A=0x1234, and A/B toggled -> first result unaffected, LO≠0x1234, Busy falls at k+5.
- REQ-032: DIV launched, reset pulsed asynchronously at cycle 4 -> Busy=0, HI=LO=0 immediately; no later write occurs.
- REQ-033: In IDLE, MTHI with A=0xDEADBEEF, then MTLO with A=0x0BADF00D on consecutive cycles -> HI=0xDEADBEEF and LO=0x0BADF00D; Busy stays 0.

Source files
------------

// File: rtl/mult_div.sv
// ============================================================================
// Module   : mult_div
// Brief    : Multi-cycle HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU,
//            MTHI/MTLO) with fixed per-operation busy latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CW   = $clog2(c_MAXC + 1);

   localparam logic [c_CW-1:0] c_MULT_N = c_CW'(MULT_CYCLES);
   localparam logic [c_CW-1:0] c_DIV_N  = c_CW'(DIV_CYCLES);
   localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

   localparam logic [2:0] c_OP_MULT  = 3'd1;
   localparam logic [2:0] c_OP_MULTU = 3'd2;
   localparam logic [2:0] c_OP_DIV   = 3'd3;
   localparam logic [2:0] c_OP_DIVU  = 3'd4;
   localparam logic [2:0] c_OP_MTHI  = 3'd5;
   localparam logic [2:0] c_OP_MTLO  = 3'd6;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [c_CW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]     r_a, r_b, w_a_nxt, w_b_nxt;
   logic [2:0]      r_op, w_op_nxt;
   logic [31:0]     r_hi, r_lo, w_hi_nxt, w_lo_nxt;

   logic            w_is_arith, w_is_mult;
   logic [63:0]     w_prod_s, w_prod_u;
   logic            w_sdiv;
   logic [31:0]     w_a_mag, w_b_mag, w_b_safe, w_uq, w_ur, w_quot, w_rem;

   always_comb begin
      w_is_arith = 1'b0;
      w_is_mult  = 1'b0;
      case (MDOp)
         c_OP_MULT, c_OP_MULTU: begin w_is_arith = 1'b1; w_is_mult = 1'b1; end
         c_OP_DIV,  c_OP_DIVU:  w_is_arith = 1'b1;
         default: ;
      endcase
   end

   // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
   assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
   assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};

   // Signed divide via magnitudes: quotient truncates toward zero, remainder
   // follows the dividend. 0x80000000 / -1 falls out naturally as 0x80000000 r 0.
   assign w_sdiv   = (r_op == c_OP_DIV);
   assign w_a_mag  = (w_sdiv && r_a[31]) ? -r_a : r_a;
   assign w_b_mag  = (w_sdiv && r_b[31]) ? -r_b : r_b;
   assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
   assign w_uq     = w_a_mag / w_b_safe;
   assign w_ur     = w_a_mag % w_b_safe;
   assign w_quot   = (w_sdiv && (r_a[31] ^ r_b[31])) ? -w_uq : w_uq;
   assign w_rem    = (w_sdiv && r_a[31]) ? -w_ur : w_ur;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_op_nxt    = r_op;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      case (r_state)
         S_IDLE: begin
            if (Start && w_is_arith) begin
               w_a_nxt     = A;
               w_b_nxt     = B;
               w_op_nxt    = MDOp;
               w_cnt_nxt   = w_is_mult ? c_MULT_N : c_DIV_N;
               w_state_nxt = S_RUN;
            end else if (!Start && (MDOp == c_OP_MTHI)) begin
               w_hi_nxt = A;
            end else if (!Start && (MDOp == c_OP_MTLO)) begin
               w_lo_nxt = A;
            end
         end
         S_RUN: begin
            if (r_cnt <= c_ONE) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
               if (r_op == c_OP_MULT) begin
                  w_hi_nxt = w_prod_s[63:32];
                  w_lo_nxt = w_prod_s[31:0];
               end else if (r_op == c_OP_MULTU) begin
                  w_hi_nxt = w_prod_u[63:32];
                  w_lo_nxt = w_prod_u[31:0];
               end else if (r_b != 32'd0) begin
                  w_hi_nxt = w_rem;
                  w_lo_nxt = w_quot;
               end
            end else begin
               w_cnt_nxt = r_cnt - c_ONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_op    <= w_op_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
      end
   end

   assign Busy = (r_state == S_RUN);
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div.sv
// ============================================================================
// Module   : tb_mult_div
// Brief    : Scoreboard bench for mult_div against an arithmetic HI/LO model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [2:0]  MDOp = '0;
   logic        Start = 1'b0;
   logic        Busy;
   logic [31:0] HI, LO;

   mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
      .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] old_hi, old_lo, new_hi, new_lo;
      int          cycles;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   bit          rst_drop = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: plain 64-bit arithmetic on the architectural operands.
   task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
      longint          sa, sb, p;
      longint unsigned pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
         3'd2: begin pu = 64'(a) * 64'(b); hi = pu[63:32]; lo = pu[31:0]; end
         3'd3: if (b != 0) begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
         3'd4: if (b != 0) begin lo = a / b; hi = a % b; end
         default: ;
      endcase
   endtask

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.old_hi = m_hi;
      e.old_lo = m_lo;
      ref_op(op, a, b, m_hi, m_lo);
      e.new_hi = m_hi;
      e.new_lo = m_lo;
      e.cycles = (op <= 3'd2) ? 5 : 10;
      q.push_back(e);
      A = a; B = b; MDOp = op; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0; MDOp = 3'd0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (Busy === 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (Busy !== 1'b0) chk("busy_timeout", 32'(Busy), 32'd0);
   endtask

   task automatic idle_check(string tag);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_hi"}, HI, m_hi);
      chk({tag, "_lo"}, LO, m_lo);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: checks HI/LO hold during Busy, then result and latency on fall.
   initial begin
      int   cnt = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (Busy === 1'b1) begin
            cnt++;
            if (q.size() > 0) begin
               chk("hold_hi", HI, q[0].old_hi);
               chk("hold_lo", LO, q[0].old_lo);
            end
         end else if (cnt > 0) begin
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("busy_cycles", 32'(cnt), 32'(e.cycles));
               chk("result_hi", HI, e.new_hi);
               chk("result_lo", LO, e.new_lo);
            end else if (!rst_drop) begin
               chk("spurious_done", 32'(q.size()), 32'd1);
            end
            cnt = 0;
            rst_drop = 1'b0;
         end
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      bit          st;

      // Asynchronous reset before any clock edge.
      #2 reset = 1'b1;
      #1;
      idle_check("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      launch(3'd1, 32'hFFFF_FFFE, 32'd3);          // HI=FFFFFFFF LO=FFFFFFFA
      wait_idle();
      launch(3'd2, 32'hFFFF_FFFE, 32'd3);          // HI=00000002 LO=FFFFFFFA
      wait_idle();
      launch(3'd3, 32'hFFFF_FFF9, 32'd2);          // LO=FFFFFFFD HI=FFFFFFFF
      wait_idle();
      launch(3'd4, 32'd7, 32'd0);                  // divide by zero: unchanged
      wait_idle();
      launch(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);  // LO=80000000 HI=0
      wait_idle();
      idle_check("div_ovf");

      // Interference during RUN must be ignored.
      launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      @(posedge clk); #1;
      Start = 1'b1; MDOp = 3'd3; A = 32'h0000_0011; B = 32'h0000_0003;
      @(posedge clk); #1;
      Start = 1'b0; MDOp = 3'd6; A = 32'h0000_1234;
      @(posedge clk); #1;
      MDOp = 3'd0; A = ~A; B = ~B;
      wait_idle();
      @(posedge clk); #1;
      idle_check("run_ignore");

      // Reset mid-DIV discards the operation.
      launch(3'd3, 32'd1000, 32'd7);
      repeat (3) @(posedge clk);
      #2;
      q.delete();
      rst_drop = 1'b1;
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      #1;
      idle_check("midrun_reset");
      @(posedge clk); #1 reset = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      idle_check("post_reset");

      // MTHI / MTLO on consecutive cycles.
      A = 32'hDEAD_BEEF; MDOp = 3'd5;
      @(posedge clk); #1;
      m_hi = 32'hDEAD_BEEF;
      A = 32'h0BAD_F00D; MDOp = 3'd6;
      @(posedge clk); #1;
      m_lo = 32'h0BAD_F00D;
      MDOp = 3'd0;
      idle_check("mthi_mtlo");

      // Randomized mix of all opcodes with and without Start.
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = rand_operand();
         b  = rand_operand();
         st = (op >= 3'd1 && op <= 3'd4) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
         if (st && op >= 3'd1 && op <= 3'd4) begin
            launch(op, a, b);
            wait_idle();
         end else begin
            A = a; B = b; MDOp = op; Start = st;
            if (!st && op == 3'd5) m_hi = a;
            if (!st && op == 3'd6) m_lo = a;
            @(posedge clk); #1;
            Start = 1'b0; MDOp = 3'd0;
            idle_check("rand_idle_op");
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
